// File: rtl/wb_arbiter.sv
// wb_arbiter: per-source result FIFOs merged round-robin onto a single writeback port
package config_pkg;
   typedef struct packed {
      int unsigned XLEN;
      int unsigned TRANS_ID_BITS;
   } cva6_cfg_t;
   localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32, TRANS_ID_BITS: 4};
endpackage

module wb_arbiter #(
   parameter config_pkg::cva6_cfg_t CVA6Cfg   = config_pkg::cva6_cfg_empty,
   parameter int unsigned           NrSrc     = 3,
   parameter int unsigned           FifoDepth = 2
) (
   input  logic                                        clk_i,
   input  logic                                        rst_ni,
   input  logic                                        flush_i,
   input  logic [NrSrc-1:0]                            src_valid_i,
   output logic [NrSrc-1:0]                            src_ready_o,
   input  logic [NrSrc-1:0][CVA6Cfg.TRANS_ID_BITS-1:0] src_trans_id_i,
   input  logic [NrSrc-1:0][CVA6Cfg.XLEN-1:0]          src_data_i,
   input  logic [NrSrc-1:0]                            src_ex_valid_i,
   input  logic [NrSrc-1:0][CVA6Cfg.XLEN-1:0]          src_ex_cause_i,
   output logic                                        wt_valid_o,
   output logic [CVA6Cfg.TRANS_ID_BITS-1:0]            trans_id_o,
   output logic [CVA6Cfg.XLEN-1:0]                     wbdata_o,
   output logic                                        ex_valid_o,
   output logic [CVA6Cfg.XLEN-1:0]                     ex_cause_o,
   output logic                                        busy_o
);
   localparam int unsigned TW = CVA6Cfg.TRANS_ID_BITS;
   localparam int unsigned XW = CVA6Cfg.XLEN;
   localparam int unsigned PW = $clog2(FifoDepth);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned RW = $clog2(NrSrc);

   typedef struct packed {
      logic [TW-1:0] id;
      logic [XW-1:0] data;
      logic          ex;
      logic [XW-1:0] cause;
   } entry_t;

   entry_t           mem_q [NrSrc][FifoDepth];
   logic [CW-1:0]    cnt_q [NrSrc];
   logic [CW-1:0]    cnt_d [NrSrc];
   logic [PW-1:0]    wr_q  [NrSrc];
   logic [PW-1:0]    wr_d  [NrSrc];
   logic [PW-1:0]    rd_q  [NrSrc];
   logic [PW-1:0]    rd_d  [NrSrc];
   logic [RW-1:0]    rr_q, rr_d, gnt;
   logic [RW:0]      idx;
   logic [NrSrc-1:0] ne, push, pop;
   entry_t           head;

   // Registered occupancy drives both the non-empty flags and acceptance
   always_comb begin
      for (int i = 0; i < NrSrc; i++) begin
         ne[i]          = cnt_q[i] != '0;
         src_ready_o[i] = (cnt_q[i] != CW'(FifoDepth)) && !flush_i;
      end
   end

   // First non-empty FIFO at or after rr_q wins; scanning backwards lets the nearest one override
   always_comb begin
      gnt = '0;
      idx = '0;
      for (int k = NrSrc - 1; k >= 0; k--) begin
         idx = {1'b0, rr_q} + (RW+1)'(k);
         idx = (idx >= (RW+1)'(NrSrc)) ? idx - (RW+1)'(NrSrc) : idx;
         if (ne[idx[RW-1:0]]) gnt = idx[RW-1:0];
      end
      busy_o     = |ne;
      wt_valid_o = busy_o && !flush_i;
      head       = mem_q[gnt][rd_q[gnt]];
      trans_id_o = wt_valid_o ? head.id : '0;
      wbdata_o   = wt_valid_o ? head.data : '0;
      ex_valid_o = wt_valid_o && head.ex;
      ex_cause_o = wt_valid_o ? head.cause : '0;
      rr_d       = flush_i ? '0 : !wt_valid_o ? rr_q : (gnt == RW'(NrSrc - 1)) ? '0 : gnt + RW'(1);
   end

   // Push/pop decisions and next occupancy/pointers; flush empties everything
   always_comb begin
      for (int i = 0; i < NrSrc; i++) begin
         push[i]  = src_valid_i[i] && src_ready_o[i];
         pop[i]   = wt_valid_o && (gnt == RW'(i));
         cnt_d[i] = flush_i ? '0 : cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
         wr_d[i]  = flush_i ? '0 : wr_q[i] + PW'(push[i]);
         rd_d[i]  = flush_i ? '0 : rd_q[i] + PW'(pop[i]);
      end
   end

   // FIFO bookkeeping and round-robin pointer; reset discards buffered entries at once
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q <= '0;
         for (int i = 0; i < NrSrc; i++) begin
            cnt_q[i] <= '0;
            wr_q[i]  <= '0;
            rd_q[i]  <= '0;
         end
      end else begin
         rr_q  <= rr_d;
         cnt_q <= cnt_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
      end
   end

   // Entry storage needs no reset: occupancy alone decides what is valid
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < NrSrc; i++)
         if (push[i]) mem_q[i][wr_q[i]] <= {src_trans_id_i[i], src_data_i[i], src_ex_valid_i[i], src_ex_cause_i[i]};
   end

`ifndef SYNTHESIS
   // Two sources must never present the same scoreboard slot in one cycle
   always @(posedge clk_i) begin
      for (int i = 0; i < NrSrc; i++)
         for (int j = i + 1; j < NrSrc; j++)
            assert (!(rst_ni && src_valid_i[i] && src_valid_i[j] && src_trans_id_i[i] == src_trans_id_i[j]))
               else $error("wb_arbiter: duplicate trans_id on sources %0d and %0d", i, j);
   end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus a randomized run against a queue-based reference model
module tb_wb_arbiter;
   localparam int N = 3;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] d;
      logic        ex;
      logic [31:0] c;
   } ent_t;

   logic              clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
   logic [N-1:0]      valid = '0, exv = '0, ready;
   logic [N-1:0][3:0] tid = '0;
   logic [N-1:0][31:0] data = '0, cause = '0;
   logic              wt_valid, ex_valid, busy;
   logic [3:0]        trans_id;
   logic [31:0]       wbdata, ex_cause;
   int                checks = 0, passed = 0;
   ent_t              q [N][$];
   int                rr = 0;

   wb_arbiter #(.NrSrc(3), .FifoDepth(2)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .src_valid_i(valid), .src_ready_o(ready), .src_trans_id_i(tid),
      .src_data_i(data), .src_ex_valid_i(exv), .src_ex_cause_i(cause),
      .wt_valid_o(wt_valid), .trans_id_o(trans_id), .wbdata_o(wbdata),
      .ex_valid_o(ex_valid), .ex_cause_o(ex_cause), .busy_o(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1);
   end

   task automatic idle();
      valid = '0;
      exv   = '0;
      flush = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input int s, input logic [3:0] id, input logic [31:0] d);
      valid[s] = 1'b1;
      tid[s]   = id;
      data[s]  = d;
   endtask

   task automatic test_reset();
      #2;
      checks++; if ({wt_valid, busy} !== 2'b00) $display("FAIL reset_valid: got wt=%0b busy=%0b want 0 0", wt_valid, busy); else passed++;
      checks++; if (ready !== 3'b111) $display("FAIL reset_ready: got %b want 111", ready); else passed++;
      checks++; if ({trans_id, wbdata, ex_valid, ex_cause} !== '0) $display("FAIL reset_data: got id=%h d=%h ex=%b c=%h want 0", trans_id, wbdata, ex_valid, ex_cause); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      put(1, 4'd5, 32'hAB);
      #1;
      checks++; if ({ready[1], wt_valid} !== 2'b10) $display("FAIL single_push: got ready=%b wt=%b want 1 0", ready[1], wt_valid); else passed++;
      tick();
      idle();
      #1;
      checks++; if ({wt_valid, trans_id, wbdata} !== {1'b1, 4'd5, 32'hAB}) $display("FAIL single_out: got wt=%b id=%0d d=%h want 1 5 ab", wt_valid, trans_id, wbdata); else passed++;
      tick();
      checks++; if ({wt_valid, busy} !== 2'b00) $display("FAIL single_drain: got wt=%b busy=%b want 0 0", wt_valid, busy); else passed++;
   endtask

   task automatic test_round_robin();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      put(0, 4'd1, 32'h100);
      put(1, 4'd2, 32'h200);
      put(2, 4'd3, 32'h300);
      tick();
      idle();
      for (int k = 0; k < N; k++) begin
         #1;
         checks++; if ({wt_valid, trans_id, wbdata} !== {1'b1, 4'(k + 1), 32'((k + 1) * 32'h100)}) $display("FAIL rr_grant%0d: got wt=%b id=%0d d=%h want 1 %0d", k, wt_valid, trans_id, wbdata, k + 1); else passed++;
         tick();
      end
      #1;
      checks++; if ({wt_valid, busy} !== 2'b00) $display("FAIL rr_drain: got wt=%b busy=%b want 0 0", wt_valid, busy); else passed++;
   endtask

   task automatic test_full();
      logic [3:0] exp_ids [4] = '{4'd1, 4'd12, 4'd13, 4'd2};
      put(0, 4'd10, 32'h10);
      put(1, 4'd11, 32'h11);
      put(2, 4'd1, 32'h1);
      tick();
      put(0, 4'd12, 32'h12);
      put(1, 4'd13, 32'h13);
      put(2, 4'd2, 32'h2);
      #1;
      checks++; if ({wt_valid, trans_id} !== {1'b1, 4'd10}) $display("FAIL full_first: got wt=%b id=%0d want 1 10", wt_valid, trans_id); else passed++;
      tick();
      valid = '0;
      put(2, 4'd3, 32'h3);
      #1;
      checks++; if (ready[2] !== 1'b0) $display("FAIL full_ready: got %b want 0", ready[2]); else passed++;
      checks++; if ({wt_valid, trans_id} !== {1'b1, 4'd11}) $display("FAIL full_second: got wt=%b id=%0d want 1 11", wt_valid, trans_id); else passed++;
      tick();
      idle();
      for (int k = 0; k < 4; k++) begin
         #1;
         checks++; if ({wt_valid, trans_id} !== {1'b1, exp_ids[k]}) $display("FAIL full_order%0d: got wt=%b id=%0d want 1 %0d", k, wt_valid, trans_id, exp_ids[k]); else passed++;
         tick();
      end
      #1;
      checks++; if ({wt_valid, busy} !== 2'b00) $display("FAIL full_drain: got wt=%b busy=%b want 0 0 (id3 must be dropped)", wt_valid, busy); else passed++;
   endtask

   task automatic test_flush();
      put(0, 4'd1, 32'h1);
      put(1, 4'd2, 32'h2);
      put(2, 4'd3, 32'h3);
      tick();
      valid[2] = 1'b0;
      put(0, 4'd4, 32'h4);
      put(1, 4'd5, 32'h5);
      tick();
      valid = '1;
      flush = 1'b1;
      #1;
      checks++; if ({wt_valid, ready, busy} !== {1'b0, 3'b000, 1'b1}) $display("FAIL flush_cycle: got wt=%b ready=%b busy=%b want 0 000 1", wt_valid, ready, busy); else passed++;
      tick();
      idle();
      #1;
      checks++; if ({wt_valid, busy} !== 2'b00) $display("FAIL flush_after: got wt=%b busy=%b want 0 0", wt_valid, busy); else passed++;
      tick();
      checks++; if (wt_valid !== 1'b0) $display("FAIL flush_quiet: got wt=%b want 0", wt_valid); else passed++;
   endtask

   task automatic test_exception();
      put(0, 4'd7, 32'h0);
      exv[0]   = 1'b1;
      cause[0] = 32'hD;
      tick();
      idle();
      #1;
      checks++; if ({wt_valid, ex_valid, ex_cause} !== {1'b1, 1'b1, 32'hD}) $display("FAIL exc_out: got wt=%b ex=%b c=%h want 1 1 d", wt_valid, ex_valid, ex_cause); else passed++;
      tick();
      checks++; if ({ex_valid, ex_cause} !== 33'd0) $display("FAIL exc_clear: got ex=%b c=%h want 0 0", ex_valid, ex_cause); else passed++;
   endtask

   task automatic test_async_reset();
      put(0, 4'd1, 32'h1);
      put(1, 4'd2, 32'h2);
      put(2, 4'd3, 32'h3);
      tick();
      idle();
      rst_n = 1'b0;
      #1;
      checks++; if ({wt_valid, busy, ready} !== {2'b00, 3'b111}) $display("FAIL areset_now: got wt=%b busy=%b ready=%b want 0 0 111", wt_valid, busy, ready); else passed++;
      checks++; if ({trans_id, wbdata} !== '0) $display("FAIL areset_data: got id=%0d d=%h want 0 0", trans_id, wbdata); else passed++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++; if ({wt_valid, busy} !== 2'b00) $display("FAIL areset_release: got wt=%b busy=%b want 0 0", wt_valid, busy); else passed++;
      put(1, 4'd9, 32'h55);
      tick();
      idle();
      #1;
      checks++; if ({wt_valid, trans_id, wbdata} !== {1'b1, 4'd9, 32'h55}) $display("FAIL areset_push: got wt=%b id=%0d d=%h want 1 9 55", wt_valid, trans_id, wbdata); else passed++;
      tick();
   endtask

   task automatic test_random();
      logic [3:0]  base;
      logic [N-1:0] exp_ready;
      logic        exp_wt, exp_busy;
      ent_t        exp_e;
      int          g, s;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int k = 0; k < N; k++) q[k].delete();
      rr = 0;
      for (int n = 0; n < 400; n++) begin
         base = 4'($urandom_range(0, 15));
         for (int k = 0; k < N; k++) begin
            valid[k] = $urandom_range(0, 2) != 0;
            tid[k]   = base + 4'(k);
            data[k]  = $urandom;
            exv[k]   = 1'($urandom_range(0, 1));
            cause[k] = $urandom;
         end
         flush = $urandom_range(0, 15) == 0;
         #1;
         g = -1;
         for (int k = 0; k < N; k++) begin
            s = (rr + k) % N;
            if (g < 0 && q[s].size() > 0) g = s;
         end
         exp_busy = g >= 0;
         exp_wt   = exp_busy && !flush;
         exp_e    = '0;
         if (exp_wt) exp_e = q[g][0];
         for (int k = 0; k < N; k++) exp_ready[k] = q[k].size() < 2 && !flush;
         checks++; if ({wt_valid, trans_id, wbdata, ex_valid, ex_cause} !== {exp_wt, exp_e}) $display("FAIL rand_out%0d: got wt=%b id=%0d d=%h ex=%b c=%h want %b %0d %h %b %h", n, wt_valid, trans_id, wbdata, ex_valid, ex_cause, exp_wt, exp_e.id, exp_e.d, exp_e.ex, exp_e.c); else passed++;
         checks++; if (ready !== exp_ready) $display("FAIL rand_ready%0d: got %b want %b", n, ready, exp_ready); else passed++;
         checks++; if (busy !== exp_busy) $display("FAIL rand_busy%0d: got %b want %b", n, busy, exp_busy); else passed++;
         if (flush) begin
            for (int k = 0; k < N; k++) q[k].delete();
            rr = 0;
         end else begin
            if (exp_wt) begin
               q[g].delete(0);
               rr = (g + 1) % N;
            end
            for (int k = 0; k < N; k++)
               if (valid[k] && exp_ready[k]) q[k].push_back('{tid[k], data[k], exv[k], cause[k]});
         end
         tick();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_full();
      test_flush();
      test_exception();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
